hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 19 +
 rtl/md_busy_ctrl.sv | 79 +++++++
 rtl/hazard_unit.sv | 94 +++++++++
 tb/tb_hazard_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard unit and its multiply/divide tracker.
package hazard_unit_pkg;

  // Execute-stage operand source selects
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  // Multiply/divide opcode carried on MdOpE
  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  // Multi-cycle unit occupancy
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage : hazard_unit_pkg

// File: rtl/md_busy_ctrl.sv
// Tracks occupancy of the multi-cycle multiply/divide unit.
// A launch loads LAT-1 into a down-counter; the unit is busy until the
// counter has been observed at zero, which is also the completion cycle.
module md_busy_ctrl
  import hazard_unit_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic MdStartE,
  input  logic MdOpE,
  output logic MdBusy,
  output logic MdDone,
  output logic mdCounting
);

  md_state_t  state;
  md_state_t  stateNext;
  logic [5:0] count;
  logic [5:0] countNext;
  logic [5:0] loadVal;

  // Counter preset chosen by the launching operation
  always_comb begin
    loadVal = (MdOpE == MD_DIV) ? 6'(DIV_LAT - 1) : 6'(MUL_LAT - 1);
  end

  // State and counter registers; reset clears mid-operation too
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, no ordering races.
      state <= stateNext;
      count <= countNext;
    end
  end

  // Next-state: launch from IDLE or on the completion cycle; ignore launches while counting
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    stateNext = state;
    countNext = count;
    unique case (state)
      IDLE: begin
        if (MdStartE) begin
          stateNext = BUSY;
          countNext = loadVal;
        end
      end
      BUSY: begin
        if (count != 6'd0) begin
          countNext = count - 6'd1;
        end else if (MdStartE) begin
          stateNext = BUSY;
          countNext = loadVal;
        end else begin
          stateNext = IDLE;
          countNext = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        countNext = '0;
      end
    endcase
  end

  // Status decoded directly from state so reset clears them without waiting for an edge
  always_comb begin
    MdBusy     = (state == BUSY);
    MdDone     = (state == BUSY) && (count == 6'd0);
    mdCounting = (state == BUSY) && (count != 6'd0);
  end

endmodule : md_busy_ctrl

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: operand forwarding for Execute and the
// Decode branch comparator, plus load-use, branch and HI/LO busy stalls.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       HiLoUseD,
  input  logic       MdStartE,
  input  logic       MdOpE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       MdBusy,
  output logic       MdDone
);

  logic mdCounting;
  logic lwStall;
  logic brStall;
  logic mdStall;
  logic anyStall;

  md_busy_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) uMdBusyCtrl (
    .clk        (clk),
    .rst        (rst),
    .MdStartE   (MdStartE),
    .MdOpE      (MdOpE),
    .MdBusy     (MdBusy),
    .MdDone     (MdDone),
    .mdCounting (mdCounting)
  );

  // Execute operand forwarding; the younger M-stage result wins over W
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RsE != 5'd0 && RegWriteM && RsE == WriteRegM) begin
      ForwardAE = FWD_MEM;
    end else if (RsE != 5'd0 && RegWriteW && RsE == WriteRegW) begin
      ForwardAE = FWD_WB;
    end
    if (RtE != 5'd0 && RegWriteM && RtE == WriteRegM) begin
      ForwardBE = FWD_MEM;
    end else if (RtE != 5'd0 && RegWriteW && RtE == WriteRegW) begin
      ForwardBE = FWD_WB;
    end
  end

  // Decode comparator forwarding from the M-stage ALU result only
  always_comb begin
    ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
    ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);
  end

  // Stall sources: load-use, branch operand not yet available, HI/LO still being computed
  always_comb begin
    lwStall  = MemtoRegE && (RtE != 5'd0) && ((RsD == RtE) || (RtD == RtE));
    brStall  = BranchD &&
               ((RegWriteE && (WriteRegE != 5'd0) &&
                 ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                (MemtoRegM && (WriteRegM != 5'd0) &&
                 ((WriteRegM == RsD) || (WriteRegM == RtD))));
    mdStall  = HiLoUseD && mdCounting;
    anyStall = lwStall || brStall || mdStall;
    StallF   = anyStall;
    StallD   = anyStall;
    FlushE   = anyStall;
  end

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Scoreboarded bench for hazard_unit: the driver pushes expected outputs
// computed by a behavioural model; a monitor pops and compares at negedge.
module tb_hazard_unit;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 32;

  typedef struct {
    logic       rst;
    logic [4:0] RsD, RtD, RsE, RtE, WrE, WrM, WrW;
    logic       RwE, RwM, RwW, MtrE, MtrM, BrD, HiLo, MdStart, MdOp;
    string      tag;
  } vec_t;

  typedef struct {
    string       tag;
    logic [12:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, HiLoUseD, MdStartE, MdOpE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy, MdDone;

  int   vectors = 0;
  int   miscompares = 0;
  sb_t  sbq[$];
  vec_t curVec;
  int   remCycles = 0;  // busy cycles left including the current one; 0 = idle

  always #5 clk = ~clk;

  hazard_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .HiLoUseD(HiLoUseD), .MdStartE(MdStartE), .MdOpE(MdOpE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .MdBusy(MdBusy), .MdDone(MdDone)
  );

  function automatic vec_t idleVec(string tag);
    vec_t v;
    v.rst = 1'b0;
    v.RsD = '0; v.RtD = '0; v.RsE = '0; v.RtE = '0;
    v.WrE = '0; v.WrM = '0; v.WrW = '0;
    v.RwE = 0; v.RwM = 0; v.RwW = 0; v.MtrE = 0; v.MtrM = 0;
    v.BrD = 0; v.HiLo = 0; v.MdStart = 0; v.MdOp = 0;
    v.tag = tag;
    return v;
  endfunction

  // Reference: which stage supplies an Execute source register
  function automatic logic [1:0] srcSel(logic [4:0] r, vec_t v);
    if (r == 0) return 2'd0;
    if (v.RwM && r == v.WrM) return 2'd2;
    if (v.RwW && r == v.WrW) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic dependsOn(logic [4:0] d, vec_t v);
    return (d != 0) && (d == v.RsD || d == v.RtD);
  endfunction

  function automatic logic [12:0] model(vec_t v, int rem);
    logic stall;
    logic lw, br, md;
    lw = v.MtrE && (v.RtE != 0) && (v.RsD == v.RtE || v.RtD == v.RtE);
    br = v.BrD && ((v.RwE && dependsOn(v.WrE, v)) || (v.MtrM && dependsOn(v.WrM, v)));
    md = v.HiLo && (rem > 1);
    stall = lw || br || md;
    return {srcSel(v.RsE, v), srcSel(v.RtE, v),
            logic'(v.RsD != 0 && v.RwM && v.RsD == v.WrM),
            logic'(v.RtD != 0 && v.RwM && v.RtD == v.WrM),
            stall, stall, stall, logic'(rem > 0), logic'(rem == 1)};
  endfunction

  task automatic drive(vec_t v);
    rst = v.rst;
    RsD = v.RsD; RtD = v.RtD; RsE = v.RsE; RtE = v.RtE;
    WriteRegE = v.WrE; WriteRegM = v.WrM; WriteRegW = v.WrW;
    RegWriteE = v.RwE; RegWriteM = v.RwM; RegWriteW = v.RwW;
    MemtoRegE = v.MtrE; MemtoRegM = v.MtrM; BranchD = v.BrD;
    HiLoUseD = v.HiLo; MdStartE = v.MdStart; MdOpE = v.MdOp;
  endtask

  // One cycle: advance the model over the edge, then present the new vector
  task automatic apply(vec_t v);
    sb_t e;
    @(posedge clk);
    if (curVec.rst) remCycles = 0;
    else if (remCycles <= 1) remCycles = curVec.MdStart ? (curVec.MdOp ? DIV_LAT : MUL_LAT) : 0;
    else remCycles = remCycles - 1;
    #1;
    drive(v);
    curVec = v;
    if (v.rst) remCycles = 0;
    e.tag = v.tag;
    e.exp = model(v, remCycles);
    sbq.push_back(e);
  endtask

  task automatic check(string tag, logic [12:0] act, logic [12:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got {fAE,fBE,fAD,fBD,sF,sD,fE,busy,done}=%b expected %b at %0t",
               tag, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check(e.tag, {ForwardAE, ForwardBE, ForwardAD, ForwardBD,
                      StallF, StallD, FlushE, MdBusy, MdDone}, e.exp);
      end
    end
  end

  initial begin
    vec_t v;
    curVec = idleVec("init");
    curVec.rst = 1'b1;
    drive(curVec);

    v = idleVec("reset_hold"); v.rst = 1; v.MdStart = 1;
    apply(v); apply(v);
    v = idleVec("reset_release"); apply(v);

    // Execute forwarding priority and the zero register
    v = idleVec("fwd_mem_over_wb"); v.RsE = 8; v.WrM = 8; v.RwM = 1; v.WrW = 8; v.RwW = 1; apply(v);
    v.tag = "fwd_wb"; v.RwM = 0; apply(v);
    v.tag = "fwd_r0"; v.RsE = 0; v.RwM = 1; apply(v);
    v = idleVec("fwd_b_mem"); v.RtE = 3; v.WrM = 3; v.RwM = 1; v.WrW = 3; v.RwW = 1; apply(v);

    // Load-use stall, then forward from M
    v = idleVec("lwstall"); v.MtrE = 1; v.RtE = 9; v.RsD = 9; v.RwE = 1; v.WrE = 9; apply(v);
    v = idleVec("lw_then_fwd"); v.RsE = 9; v.WrM = 9; v.RwM = 1; v.MtrM = 1; apply(v);
    v = idleVec("lwstall_r0"); v.MtrE = 1; v.RtE = 0; v.RsD = 0; apply(v);

    // Branch stall, then Decode forwarding
    v = idleVec("brstall"); v.BrD = 1; v.RsD = 4; v.RwE = 1; v.WrE = 4; apply(v);
    v = idleVec("br_fwd_ad"); v.BrD = 1; v.RsD = 4; v.RwM = 1; v.WrM = 4; apply(v);
    v = idleVec("brstall_load_m"); v.BrD = 1; v.RtD = 6; v.MtrM = 1; v.RwM = 1; v.WrM = 6; apply(v);

    // Divide with HI/LO user waiting; a re-launch mid-window is ignored
    v = idleVec("div_start"); v.HiLo = 1; v.MdStart = 1; v.MdOp = 1; apply(v);
    for (int i = 1; i <= DIV_LAT + 2; i++) begin
      v = idleVec("div_window"); v.HiLo = 1;
      if (i == 10) begin v.MdStart = 1; v.MdOp = 0; end
      apply(v);
    end

    // Multiply interrupted by an asynchronous reset, then a clean restart
    v = idleVec("mul_start"); v.MdStart = 1; apply(v);
    v = idleVec("mul_run"); apply(v); apply(v);
    v = idleVec("async_reset"); v.rst = 1; apply(v);
    v = idleVec("restart_after_reset"); v.MdStart = 1; apply(v);
    for (int i = 0; i < MUL_LAT + 2; i++) begin
      v = idleVec("mul_window"); v.HiLo = 1; apply(v);
    end

    // Back-to-back launch on the completion cycle
    v = idleVec("b2b_start"); v.MdStart = 1; apply(v);
    for (int i = 1; i <= 2 * MUL_LAT + 2; i++) begin
      v = idleVec("b2b_window"); v.HiLo = 1; v.MdStart = (i == MUL_LAT); apply(v);
    end

    // Random traffic on a small register range so matches are frequent
    for (int i = 0; i < 2000; i++) begin
      v = idleVec("random");
      v.rst = ($urandom_range(0, 199) == 0);
      v.RsD = 5'($urandom_range(0, 3)); v.RtD = 5'($urandom_range(0, 3));
      v.RsE = 5'($urandom_range(0, 3)); v.RtE = 5'($urandom_range(0, 3));
      v.WrE = 5'($urandom_range(0, 3)); v.WrM = 5'($urandom_range(0, 3));
      v.WrW = 5'($urandom_range(0, 3));
      v.RwE = 1'($urandom); v.RwM = 1'($urandom); v.RwW = 1'($urandom);
      v.MtrE = 1'($urandom); v.MtrM = 1'($urandom); v.BrD = 1'($urandom);
      v.HiLo = 1'($urandom); v.MdOp = 1'($urandom);
      v.MdStart = ($urandom_range(0, 15) == 0);
      apply(v);
    end

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_hazard_unit
